instr_cache_ctrl: RTL and testbench
===================================

Name: instr_cache_ctrl

Overview:
- Direct-mapped instruction cache between the CPU fetch stage and instruction_memory.
- Serves 32-bit instructions to fetch on a hit in the same cycle.
- On a miss, stalls fetch, fetches a 128-bit block over the 28-bit block-address memory interface, then replays the access.
- Keeps saturating hit and miss counters for performance checks in CPU-level benches.

Parameters:
- LINES, 8, number of cache lines; power of 2; index width is log2(LINES).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- READ  input  1  fetch request valid.
- PC_ADDRESS  input  32  byte address of the instruction; bits [1:0] are ignored.
- FLUSH  input  1  invalidate all lines (fence.i).
- INSTRUCTION  output  32  fetched instruction; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  output  1  stall to fetch.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address, equal to PC_ADDRESS[31:4].
- MEM_READDATA  input  128  returned block; word 0 is in bits [31:0].
- MEM_BUSYWAIT  input  1  memory busy; data is valid on the edge where this is 0 while MEM_READ=1.
- HIT_COUNT  output  CNT_W  saturating count of hits.
- MISS_COUNT  output  CNT_W  saturating count of misses.

Behaviour:
- Address split (LINES=8):
  - offset = PC[3:2]
  - index = PC[6:4]
  - tag = PC[31:7] (25 bits)
- Per-line storage: VALID bit, TAG, 128-bit DATA.
- hit = READ & VALID[index] & (TAG[index]==tag); combinational.
- INSTRUCTION = DATA[index] word selected by offset; combinational; don't-care when not a hit.
- FSM states: IDLE, FETCH.
- IDLE:
  - BUSYWAIT = READ & ~hit, combinational, so the stall appears in the same cycle as the miss.
  - MEM_READ = 0.
  - On a miss: go to FETCH at the next edge; MISS_COUNT increments once.
  - On a hit: HIT_COUNT increments at the edge.
- FETCH:
  - MEM_READ = 1, BUSYWAIT = 1.
  - MEM_ADDRESS = PC_ADDRESS[31:4], latched on IDLE->FETCH entry and held stable for the whole fetch.
  - On an edge with MEM_BUSYWAIT=0: write DATA[idx] = MEM_READDATA, TAG[idx], set VALID[idx]=1, return to IDLE.
  - The replayed access then hits in the following cycle.
  - Miss-to-instruction latency = memory latency + 2 cycles.
  - The hit counter increments on the replay.
- FLUSH:
  - In IDLE: all VALID cleared at the edge. A hit evaluated in that same cycle is still served and counted.
  - In FETCH: the memory transaction runs to completion and DATA/TAG are written, but all VALID bits end at 0, including the filled line. Return to IDLE; the replay misses again.
- FETCH with READ deasserted: the fill still completes (no abort).
- Counters saturate at all-ones and never wrap.
- RESET low at an edge, from any state including mid-FETCH:
  - State -> IDLE, all VALID = 0, HIT_COUNT = MISS_COUNT = 0.
  - MEM_READ = 0 and BUSYWAIT = READ, from the next cycle.
  - DATA/TAG are not cleared.
  - Returned memory data is dropped. The memory side may still complete its transaction; the controller ignores it.
- Reset output values: MEM_READ=0, MEM_ADDRESS=last latched value (don't-care), counters 0.
- No other memory traffic: the cache is read-only; no write path.

Test Plan:
- Cold miss:
  - Stimulus: reset, then READ=1, PC=0x0000_0004, memory returns block {W3,W2,W1,W0} after 5 cycles.
  - Required: BUSYWAIT=1 immediately; MEM_READ=1 with MEM_ADDRESS=0x0000000 for the fetch; then INSTRUCTION=W1 with BUSYWAIT=0; MISS_COUNT=1, HIT_COUNT=1.
- Spatial hits:
  - Stimulus: following the cold miss, PC=0x8, then 0xC, then 0x0 on consecutive cycles.
  - Required: W2, W3, W0 returned with BUSYWAIT=0 each cycle; no MEM_READ; HIT_COUNT=4.
- Conflict:
  - Stimulus: PC=0x80 (index 0, different tag), then PC=0x0.
  - Required: both miss; MEM_ADDRESS=0x0000008, then 0x0000000; MISS_COUNT=3.
- Flush:
  - Stimulus: FLUSH=1 for one cycle in IDLE, then PC=0x4.
  - Required: miss, MEM_READ=1. Separately, FLUSH during FETCH: after the fill the same PC misses again.
- Reset mid-fill:
  - Stimulus: miss on PC=0x40, RESET=0 for one edge while MEM_BUSYWAIT=1.
  - Required: next cycle MEM_READ=0, counters 0; after memory idles, PC=0x40 misses.
- Saturation:
  - Stimulus: CNT_W=4; 20 hits on one line.
  - Required: HIT_COUNT holds at 15.

Source files
------------

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped, read-only instruction cache between the fetch stage and instruction memory.
// A hit is served combinationally. A miss stalls fetch, fills a 128-bit block, then replays.
`timescale 1ns/1ps

module instr_cache_ctrl #(
    parameter int LINES = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             READ,
    input  logic [31:0]      PC_ADDRESS,
    input  logic             FLUSH,
    output logic [31:0]      INSTRUCTION,
    output logic             BUSYWAIT,
    output logic             MEM_READ,
    output logic [27:0]      MEM_ADDRESS,
    input  logic [127:0]     MEM_READDATA,
    input  logic             MEM_BUSYWAIT,
    output logic [CNT_W-1:0] HIT_COUNT,
    output logic [CNT_W-1:0] MISS_COUNT
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } state_t;

    state_t             r_state;
    logic               r_mem_read;
    logic [27:0]        r_mem_address;
    logic               r_flush_pend;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [127:0]       r_data [LINES];
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_offset;
    logic               w_hit;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_fill_done;
    logic               w_unused;

    assign w_offset    = PC_ADDRESS[3:2];
    assign w_idx       = PC_ADDRESS[4 +: IDX_W];
    assign w_tag       = PC_ADDRESS[31 -: TAG_W];
    assign w_unused    = ^PC_ADDRESS[1:0];

    // The fill targets the latched block address, not the live PC, so fetch may move PC freely.
    assign w_fill_idx  = r_mem_address[IDX_W-1:0];
    assign w_fill_tag  = r_mem_address[27:IDX_W];
    assign w_fill_done = (r_state == ST_FETCH) && !MEM_BUSYWAIT;

    assign w_hit       = READ && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign INSTRUCTION = r_data[w_idx][{w_offset, 5'd0} +: 32];
    assign BUSYWAIT    = (r_state == ST_FETCH) || (READ && !w_hit);
    assign MEM_READ    = r_mem_read;
    assign MEM_ADDRESS = r_mem_address;
    assign HIT_COUNT   = r_hit_count;
    assign MISS_COUNT  = r_miss_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= ST_IDLE;
            r_mem_read   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (FLUSH) begin
                        r_valid <= '0;
                    end
                    if (w_hit) begin
                        r_hit_count <= sat_inc(r_hit_count);
                    end else if (READ) begin
                        r_miss_count  <= sat_inc(r_miss_count);
                        r_state       <= ST_FETCH;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= PC_ADDRESS[31:4];
                        r_flush_pend  <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state      <= ST_IDLE;
                        r_mem_read   <= 1'b0;
                        r_flush_pend <= 1'b0;
                        // A flush seen at any point of the fill leaves the filled line invalid too.
                        if (FLUSH || r_flush_pend) begin
                            r_valid <= '0;
                        end else begin
                            r_valid[w_fill_idx] <= 1'b1;
                        end
                    end else if (FLUSH) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; VALID alone guards them, and a reset-free
    // array maps onto plain RAM. Data returned on a reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (RESET && w_fill_done) begin
            r_data[w_fill_idx] <= MEM_READDATA;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// Self-checking bench for instr_cache_ctrl: directed scenarios followed by random traffic,
// all checked against a block-level reference model and a simple variable-latency memory.
`timescale 1ns/1ps

module tb_instr_cache_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RESET;
    logic             READ;
    logic [31:0]      PC_ADDRESS;
    logic             FLUSH;
    logic [31:0]      INSTRUCTION;
    logic             BUSYWAIT;
    logic             MEM_READ;
    logic [27:0]      MEM_ADDRESS;
    logic [127:0]     MEM_READDATA;
    logic             MEM_BUSYWAIT;
    logic [CNT_W-1:0] HIT_COUNT;
    logic [CNT_W-1:0] MISS_COUNT;

    instr_cache_ctrl #(.LINES(8), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .PC_ADDRESS   (PC_ADDRESS),
        .FLUSH        (FLUSH),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = mem_word({blk, 2'(w)});
        end
        return b;
    endfunction

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    // Memory side: answers a read after mem_lat cycles of MEM_READ; random noise otherwise.
    bit mem_active = 0;
    int mem_cnt    = 0;
    int mem_lat    = 1;
    int next_lat   = 5;

    task automatic mem_drive();
        if (MEM_READ === 1'b1) begin
            if (!mem_active) begin
                mem_active = 1;
                mem_cnt    = 0;
                mem_lat    = next_lat;
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_active = 0;
        end
        if (mem_active) MEM_BUSYWAIT = (mem_cnt < mem_lat - 1);
        else            MEM_BUSYWAIT = 1'($urandom_range(0, 1));
        if (mem_active && !MEM_BUSYWAIT) MEM_READDATA = mem_block(MEM_ADDRESS);
        else MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Reference model: which block each line holds, and whether a fill is outstanding.
    bit   [7:0]  m_valid = '0;
    logic [27:0] m_blk [8];
    bit          m_pending = 0;
    bit          m_flushed = 0;
    logic [27:0] m_pend_blk = '0;
    int          m_hits = 0;
    int          m_misses = 0;
    bit          m_known = 0;
    bit          e_served = 0;

    // One clock cycle: apply inputs just after an edge, check mid-cycle, advance the model at the edge.
    task automatic step(input bit rd, input logic [31:0] pc, input bit fl, input bit rst);
        logic [27:0] blk;
        logic [2:0]  idx;
        bit          hit;
        READ       = rd;
        PC_ADDRESS = pc;
        FLUSH      = fl;
        RESET      = rst;
        mem_drive();
        blk = pc[31:4];
        idx = pc[6:4];
        hit = !m_pending && rd && m_valid[idx] && (m_blk[idx] == blk);
        e_served = hit;
        #3;
        if (m_known) begin
            check("busywait", BUSYWAIT, m_pending || (rd && !hit));
            check("mem_read", MEM_READ, m_pending);
            if (m_pending) check("mem_address", MEM_ADDRESS, m_pend_blk);
            if (hit) check("instruction", INSTRUCTION, mem_word(pc[31:2]));
            check("hit_count", HIT_COUNT, m_hits);
            check("miss_count", MISS_COUNT, m_misses);
        end
        @(posedge CLK);
        if (!rst) begin
            m_known   = 1;
            m_pending = 0;
            m_valid   = '0;
            m_hits    = 0;
            m_misses  = 0;
        end else if (!m_pending) begin
            if (fl) m_valid = '0;
            if (hit) begin
                m_hits = sat(m_hits);
            end else if (rd) begin
                m_misses   = sat(m_misses);
                m_pending  = 1;
                m_pend_blk = blk;
                m_flushed  = 0;
            end
        end else begin
            if (fl) begin
                m_flushed = 1;
                m_valid   = '0;
            end
            if (!MEM_BUSYWAIT) begin
                m_blk[m_pend_blk[2:0]]   = m_pend_blk;
                m_valid[m_pend_blk[2:0]] = !m_flushed;
                m_pending = 0;
            end
        end
        #1;
    endtask

    // Hold a fetch request until the model says it is served, with a cycle budget.
    task automatic access(input logic [31:0] pc, input int lat);
        next_lat = lat;
        for (int i = 0; i < 60; i++) begin
            step(1, pc, 0, 1);
            if (e_served) return;
        end
        check("access_timeout", e_served, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    logic [24:0] tag_pool [4];

    initial begin
        READ = 0; PC_ADDRESS = '0; FLUSH = 0; RESET = 0;
        MEM_BUSYWAIT = 1; MEM_READDATA = '0;
        @(posedge CLK);
        #1;
        step(0, 32'h0, 0, 0);
        step(0, 32'h0, 0, 0);

        // Cold miss: 5-cycle memory, then W1 served.
        access(32'h0000_0004, 5);
        check("cold_miss_count", MISS_COUNT, 1);
        check("cold_hit_count", HIT_COUNT, 1);

        // Spatial hits in the same block.
        step(1, 32'h0000_0008, 0, 1);
        step(1, 32'h0000_000C, 0, 1);
        step(1, 32'h0000_0000, 0, 1);
        check("spatial_hit_count", HIT_COUNT, 4);

        // Conflict on index 0.
        access(32'h0000_0080, 3);
        access(32'h0000_0000, 2);
        check("conflict_miss_count", MISS_COUNT, 3);

        // Flush in IDLE, then flush during a fill.
        step(0, 32'h0, 1, 1);
        access(32'h0000_0004, 2);
        next_lat = 4;
        step(1, 32'h0000_0010, 0, 1);
        step(1, 32'h0000_0010, 1, 1);
        access(32'h0000_0010, 4);
        check("flush_miss_count", MISS_COUNT, 6);
        check("flush_hit_count", HIT_COUNT, 8);

        // Reset in the middle of a fill while memory is still busy.
        next_lat = 5;
        step(1, 32'h0000_0040, 0, 1);
        step(1, 32'h0000_0040, 0, 1);
        step(1, 32'h0000_0040, 0, 0);
        step(0, 32'h0000_0040, 0, 1);
        check("rst_mem_read", MEM_READ, 1'b0);
        check("rst_hit_count", HIT_COUNT, 0);
        check("rst_miss_count", MISS_COUNT, 0);
        step(0, 32'h0000_0040, 0, 1);
        access(32'h0000_0040, 3);
        check("rst_refetch_miss", MISS_COUNT, 1);

        // Saturation of the hit counter.
        for (int i = 0; i < 20; i++) step(1, 32'h0000_0040 | 32'(($urandom % 4) * 4), 0, 1);
        check("sat_hit_count", HIT_COUNT, CNT_MAX);

        // Random traffic over a few tags so hits, conflicts and flushes all occur.
        for (int t = 0; t < 4; t++) tag_pool[t] = 25'($urandom);
        tag_pool[0] = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = {tag_pool[$urandom_range(0, 3)], 7'($urandom)};
            next_lat = $urandom_range(1, 6);
            step(($urandom % 10) < 8, pc, ($urandom % 25) == 0, ($urandom % 150) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
